// File: rtl/ifu_fetch_ctrl_pkg.sv
// rtl/ifu_fetch_ctrl_pkg.sv - shared constants, FSM encoding and pre-decode helper for the IFU fetch front end
//
// Contents:
//   TRUE / FALSE        single-bit logic constants (macros)
//   OPCODE_JAL          7-bit major opcode of JAL
//   OPCODE_BRANCH       7-bit major opcode of conditional branches
//   fetch_state_e       FS_REQ / FS_WAIT / FS_KILL (2-bit)
//   predecode_imm()     sign-extended JAL/BRANCH immediate, zero for other opcodes

`ifndef IFU_FETCH_CTRL_DEFINES
`define IFU_FETCH_CTRL_DEFINES
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package ifu_fetch_ctrl_pkg;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // FS_REQ : may present a request to instruction memory
    // FS_WAIT: request granted, waiting for its response
    // FS_KILL: request granted but overtaken by a flush; its response is dropped
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_KILL = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] predecode_imm(input logic [31:0] w);
        logic [31:0] imm;
        case (w[6:0])
            OPCODE_JAL:    imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            OPCODE_BRANCH: imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default:       imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - 2-entry FIFO holding fetched {inst, pc, pc_pred} toward decode
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write one entry (ignored when full unless a pop frees the slot)
//   pop          remove the head (ignored when empty)
//   clr          empty the queue; wins over push and pop in the same cycle
//   rdata        head entry (all zeros after reset)
//   count        number of stored entries, 0..2
//   valid        head entry is valid

module ifu_fetch_queue
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    input  logic         clr,
    output logic [W-1:0] rdata,
    output logic [1:0]   count,
    output logic         valid
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // On a full queue a simultaneous pop frees the head slot, which is
    // exactly where wr_ptr points, so the push may proceed.
    assign do_push = push && ((count != 2'd2) || do_pop);

    assign rdata = mem[rd_ptr];
    assign valid = (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= `FALSE;
            rd_ptr <= `FALSE;
            count  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= `FALSE;
            rd_ptr <= `FALSE;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - IFU fetch front end: PC register, single-outstanding imem fetch, pre-decode, decode queue
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt     request channel (one outstanding request)
//   imem_rvalid/imem_rdata          response channel
//   bpu_pc/bpu_opcode/bpu_imm       pre-decoded view of imem_rdata for the BPU
//   bpu_pc_pred                     predicted next PC, taken when a response is accepted
//   flush_flag/flush_addr           back-end redirect, highest priority
//   id_valid/id_ready               decode handshake on the queue head
//   id_inst/id_pc/id_pc_pred        queue head contents

module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] bpu_pc,
    output logic [6:0]      bpu_opcode,
    output logic [31:0]     bpu_imm,
    input  logic [XLEN-1:0] bpu_pc_pred,
    input  logic            flush_flag,
    input  logic [XLEN-1:0] flush_addr,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_pred
);

    localparam int         QW    = 32 + 2 * XLEN;
    localparam logic [1:0] QFULL = 2'(QDEPTH);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    // Low while reset is held and for the first edge after release, so the
    // request line is quiet in reset even though state_q resets to FS_REQ.
    logic            run_q;
    logic            push;
    logic            pop;
    logic [1:0]      q_count;
    logic            q_valid;
    logic [QW-1:0]   q_wdata;
    logic [QW-1:0]   q_rdata;

    // The PC register only moves on an accepted response or a flush, both of
    // which happen outside FS_REQ-with-pending-request, so the address is
    // stable while a request waits for its grant.
    assign imem_addr  = pc_q;
    assign bpu_pc     = pc_q;
    assign bpu_opcode = imem_rdata[6:0];
    assign bpu_imm    = predecode_imm(imem_rdata);

    assign q_wdata = {imem_rdata, pc_q, bpu_pc_pred};
    assign {id_inst, id_pc, id_pc_pred} = q_rdata;
    assign id_valid = q_valid;
    // A pop coinciding with a flush is discarded inside the queue by clr.
    assign pop = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_REQ;
            pc_q    <= RESET_PC;
            run_q   <= `FALSE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= `TRUE;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = `FALSE;
        // Issuing only below QDEPTH entries means the response can always be
        // pushed, so there is never a need to stall a returning word.
        imem_req = run_q && (state_q == FS_REQ) && (q_count < QFULL) && !flush_flag;

        if (flush_flag) begin
            pc_d = flush_addr;
            case (state_q)
                // An outstanding fetch must still return; remember to drop it
                // unless it is returning right now.
                FS_WAIT, FS_KILL: state_d = imem_rvalid ? FS_REQ : FS_KILL;
                default:          state_d = FS_REQ;
            endcase
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (imem_req && imem_gnt) begin
                        state_d = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        push    = `TRUE;
                        pc_d    = bpu_pc_pred;
                        state_d = FS_REQ;
                    end
                end
                FS_KILL: begin
                    if (imem_rvalid) begin
                        state_d = FS_REQ;
                    end
                end
                default: state_d = FS_REQ;
            endcase
        end
    end

    ifu_fetch_queue #(
        .W(QW)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (q_wdata),
        .pop   (pop),
        .clr   (flush_flag),
        .rdata (q_rdata),
        .count (q_count),
        .valid (q_valid)
    );

endmodule
